// File: rtl/slow_mem_pkg.sv
// slow_mem_pkg: shared types and constants for the multi-channel slow memory model
package slow_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_LINE_W = 128;
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DEPTH_LOG2 = 12;
  localparam int DEF_LATENCY = 8;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0);
  endfunction
endpackage

// File: rtl/slow_memory_mp_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starting at channel ptr
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gidx
);
  int c;
  always_comb begin
    gnt = '0;
    gidx = '0;
    c = 0;
    // scan backwards so the requester nearest ptr is assigned last and wins
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % NUM_CH;
      if (req[c]) begin
        gnt = '0;
        gnt[c] = 1'b1;
        gidx = IDX_W'(c);
      end
    end
  end
endmodule

// File: rtl/slow_memory_mp.sv
// slow_memory_mp: shared line memory, round-robin multi-channel access, programmable latency
// Define SLOW_MEM_STALL_EN to add 0-3 LFSR-driven stall cycles per access.
module slow_memory_mp
  import slow_mem_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        mem_read,
  input  logic [NUM_CH-1:0]        mem_write,
  input  logic [NUM_CH*ADDR_W-1:0] mem_addr,
  input  logic [NUM_CH*LINE_W-1:0] mem_wdata,
  output logic [NUM_CH*LINE_W-1:0] mem_rdata,
  output logic [NUM_CH-1:0]        mem_ready,
  output logic                     protocol_err
);
  localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [LINE_W-1:0] mem [0:2**DEPTH_LOG2-1];
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr, gidx, lat_ch;
  logic [NUM_CH-1:0] req, gnt;
  logic [15:0] cnt;
  logic [1:0] stall;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [LINE_W-1:0] lat_wdata;
  logic lat_wr, grant, addr_unused;
  assign addr_unused = ^mem_addr;
  // a channel still holds its request on the edge it sees mem_ready; mask it so it is not re-served
  assign req = (mem_read | mem_write) & ~mem_ready;
  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (.req, .ptr, .gnt, .gidx);
`ifdef SLOW_MEM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else if (grant) lfsr <= lfsr_next(lfsr);
  end
  assign stall = lfsr[1:0];
`else
  assign stall = 2'd0;
`endif
  always_comb begin
    grant = state_q == IDLE && |req;
    state_d = state_q == IDLE ? (grant ? BUSY : IDLE) :
              state_q == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst_n && state_q == DONE && lat_wr) mem[lat_idx] <= lat_wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      lat_ch <= '0;
      lat_idx <= '0;
      lat_wdata <= '0;
      lat_wr <= 1'b0;
      mem_ready <= '0;
      mem_rdata <= '0;
      protocol_err <= 1'b0;
    end else begin
      mem_ready <= '0;
      if (grant) begin
        ptr <= int'(gidx) == NUM_CH - 1 ? '0 : gidx + 1'b1;
        cnt <= 16'(LATENCY - 2) + 16'(stall);
        lat_ch <= gidx;
        lat_idx <= mem_addr[int'(gidx)*ADDR_W +: DEPTH_LOG2];
        lat_wdata <= mem_wdata[int'(gidx)*LINE_W +: LINE_W];
        lat_wr <= |(gnt & mem_write);
        protocol_err <= protocol_err | (|(gnt & mem_read & mem_write));
      end else if (state_q == BUSY && cnt != '0) begin
        cnt <= cnt - 16'd1;
      end
      if (state_q == DONE) begin
        mem_ready[lat_ch] <= 1'b1;
        if (!lat_wr) mem_rdata[int'(lat_ch)*LINE_W +: LINE_W] <= mem[lat_idx];
      end
    end
  end
endmodule

// File: tb/tb_slow_memory_mp.sv
// tb_slow_memory_mp: randomized self-checking bench with a line-level reference model
module tb_slow_memory_mp;
  localparam int NCH = 2;
  localparam int LW = 128;
  localparam int AW = 28;
  localparam int DL = 12;
  localparam int LAT = 8;
`ifdef SLOW_MEM_STALL_EN
  localparam int MAXSTALL = 3;
`else
  localparam int MAXSTALL = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] mem_read = '0;
  logic [NCH-1:0] mem_write = '0;
  logic [NCH*AW-1:0] mem_addr = '0;
  logic [NCH*LW-1:0] mem_wdata = '0;
  logic [NCH*LW-1:0] mem_rdata;
  logic [NCH-1:0] mem_ready;
  logic protocol_err;
  int vectors = 0;
  int miscompares = 0;
  logic [LW-1:0] ref_mem [int];
  logic [LW-1:0] ref_rdata [NCH];
  int ref_ptr = 0;
  logic ref_err = 1'b0;

  always #5 clk = ~clk;

  slow_memory_mp #(.NUM_CH(NCH), .LINE_W(LW), .ADDR_W(AW), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .protocol_err(protocol_err)
  );

  function automatic int line_of(input logic [AW-1:0] a);
    return int'(a[DL-1:0]);
  endfunction

  task automatic model_access(input int ch, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    ref_ptr = (ch + 1) % NCH;
    if (rd && wr) ref_err = 1'b1;
    if (wr) ref_mem[line_of(a)] = d;
    else ref_rdata[ch] = ref_mem[line_of(a)];
  endtask

  task automatic model_reset();
    ref_ptr = 0;
    ref_err = 1'b0;
    for (int c = 0; c < NCH; c++) ref_rdata[c] = '0;
  endtask

  task automatic run_access(input int ch, input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [LW-1:0] d, output int lat, output logic after);
    mem_read[ch] = rd;
    mem_write[ch] = wr;
    mem_addr[ch*AW +: AW] = a;
    mem_wdata[ch*LW +: LW] = d;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ready[ch]) begin
        lat = n - 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_read[ch] = 1'b0;
    mem_write[ch] = 1'b0;
    @(negedge clk);
    after = mem_ready[ch];
  endtask

  task automatic test_reset();
    int hits;
    rst_n = 1'b0;
    mem_read[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_read[0] = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if (mem_ready !== '0) begin miscompares++; $display("FAIL reset_ready: got %b expected %b", mem_ready, 2'b00); end
    vectors++;
    if (mem_rdata !== '0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
    vectors++;
    if (protocol_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", protocol_err); end
    hits = 0;
    repeat (15) begin
      @(negedge clk);
      if (mem_ready !== '0) hits++;
    end
    vectors++;
    if (hits != 0) begin miscompares++; $display("FAIL reset_req_ignored: got %0d ready cycles expected 0", hits); end
  endtask

  task automatic test_write_read();
    int lat;
    logic after;
    logic [LW-1:0] v;
    v = 128'h0123456789ABCDEF0123456789ABCDEF;
    run_access(1, 1'b0, 1'b1, 28'h0000010, v, lat, after);
    model_access(1, 1'b0, 1'b1, 28'h0000010, v);
    vectors++;
    if (lat < LAT || lat > LAT + MAXSTALL) begin miscompares++; $display("FAIL wr_latency: got %0d expected %0d..%0d", lat, LAT, LAT + MAXSTALL); end
    run_access(0, 1'b1, 1'b0, 28'h0000010, '0, lat, after);
    model_access(0, 1'b1, 1'b0, 28'h0000010, '0);
    vectors++;
    if (lat < LAT || lat > LAT + MAXSTALL) begin miscompares++; $display("FAIL rd_latency: got %0d expected %0d..%0d", lat, LAT, LAT + MAXSTALL); end
    vectors++;
    if (after !== 1'b0) begin miscompares++; $display("FAIL ready_pulse_width: got %b expected 0", after); end
    vectors++;
    if (mem_rdata[0 +: LW] !== ref_rdata[0]) begin miscompares++; $display("FAIL rd_preload: got %h expected %h", mem_rdata[0 +: LW], ref_rdata[0]); end
    v = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    run_access(1, 1'b0, 1'b1, 28'h0000020, v, lat, after);
    model_access(1, 1'b0, 1'b1, 28'h0000020, v);
    run_access(0, 1'b1, 1'b0, 28'h0000020, '0, lat, after);
    model_access(0, 1'b1, 1'b0, 28'h0000020, '0);
    vectors++;
    if (mem_rdata[0 +: LW] !== ref_rdata[0]) begin miscompares++; $display("FAIL rd_after_wr: got %h expected %h", mem_rdata[0 +: LW], ref_rdata[0]); end
    vectors++;
    if (mem_rdata[LW +: LW] !== ref_rdata[1]) begin miscompares++; $display("FAIL ch1_rdata_kept: got %h expected %h", mem_rdata[LW +: LW], ref_rdata[1]); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a [NCH];
    a[0] = 28'h0000010;
    a[1] = 28'h0000020;
    for (int r = 0; r < 2; r++) begin
      int order [$];
      int t [NCH];
      logic [NCH-1:0] pend;
      int exp0, exp1, cyc;
      exp0 = ref_ptr;
      exp1 = (ref_ptr + 1) % NCH;
      pend = '0;
      cyc = 0;
      for (int c = 0; c < NCH; c++) begin
        mem_addr[c*AW +: AW] = a[c];
        t[c] = 0;
      end
      mem_read = '1;
      repeat (40) begin
        @(posedge clk);
        cyc++;
        #1;
        mem_read = mem_read & ~pend;
        pend = '0;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
          if (mem_ready[c]) begin
            t[c] = cyc;
            order.push_back(c);
            pend[c] = 1'b1;
            model_access(c, 1'b1, 1'b0, a[c], '0);
            vectors++;
            if (mem_rdata[c*LW +: LW] !== ref_rdata[c]) begin miscompares++; $display("FAIL rr_data ch%0d: got %h expected %h", c, mem_rdata[c*LW +: LW], ref_rdata[c]); end
          end
        end
      end
      mem_read = '0;
      vectors++;
      if (order.size() != 2) begin
        miscompares++; $display("FAIL rr_count: got %0d completions expected 2", order.size());
      end else begin
        vectors++;
        if (order[0] != exp0 || order[1] != exp1) begin miscompares++; $display("FAIL rr_order round %0d: got %0d,%0d expected %0d,%0d", r, order[0], order[1], exp0, exp1); end
        vectors++;
        if (t[exp1] - t[exp0] < LAT + 1 || t[exp1] - t[exp0] > LAT + 1 + MAXSTALL) begin
          miscompares++; $display("FAIL rr_spacing: got %0d expected %0d..%0d", t[exp1] - t[exp0], LAT + 1, LAT + 1 + MAXSTALL);
        end
      end
    end
  endtask

  task automatic test_alias_protocol();
    int lat;
    logic after;
    logic [LW-1:0] v, w;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_access(1, 1'b0, 1'b1, 28'h0000000, v, lat, after);
    model_access(1, 1'b0, 1'b1, 28'h0000000, v);
    run_access(0, 1'b1, 1'b0, 28'h0001000, '0, lat, after);
    model_access(0, 1'b1, 1'b0, 28'h0001000, '0);
    vectors++;
    if (mem_rdata[0 +: LW] !== ref_rdata[0]) begin miscompares++; $display("FAIL alias_read: got %h expected %h", mem_rdata[0 +: LW], ref_rdata[0]); end
    run_access(0, 1'b1, 1'b1, 28'h0000030, w, lat, after);
    model_access(0, 1'b1, 1'b1, 28'h0000030, w);
    vectors++;
    if (protocol_err !== ref_err) begin miscompares++; $display("FAIL proto_err_set: got %b expected %b", protocol_err, ref_err); end
    vectors++;
    if (mem_rdata[0 +: LW] !== ref_rdata[0]) begin miscompares++; $display("FAIL proto_rdata_kept: got %h expected %h", mem_rdata[0 +: LW], ref_rdata[0]); end
    run_access(1, 1'b1, 1'b0, 28'h0000030, '0, lat, after);
    model_access(1, 1'b1, 1'b0, 28'h0000030, '0);
    vectors++;
    if (mem_rdata[LW +: LW] !== ref_rdata[1]) begin miscompares++; $display("FAIL proto_write_done: got %h expected %h", mem_rdata[LW +: LW], ref_rdata[1]); end
    vectors++;
    if (protocol_err !== ref_err) begin miscompares++; $display("FAIL proto_err_sticky: got %b expected %b", protocol_err, ref_err); end
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    vectors++;
    if (protocol_err !== ref_err) begin miscompares++; $display("FAIL proto_err_reset: got %b expected %b", protocol_err, ref_err); end
  endtask

  task automatic test_reset_abort();
    int lat, hits;
    logic after;
    run_access(0, 1'b0, 1'b1, 28'h0000005, '0, lat, after);
    model_access(0, 1'b0, 1'b1, 28'h0000005, '0);
    mem_write[1] = 1'b1;
    mem_addr[AW +: AW] = 28'h0000005;
    mem_wdata[LW +: LW] = 128'h1;
    hits = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ready !== '0) hits++;
    end
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_write[1] = 1'b0;
    model_reset();
    repeat (20) begin
      @(negedge clk);
      if (mem_ready !== '0) hits++;
    end
    vectors++;
    if (hits != 0) begin miscompares++; $display("FAIL abort_no_ready: got %0d ready cycles expected 0", hits); end
    vectors++;
    if (mem_rdata !== '0) begin miscompares++; $display("FAIL abort_rdata_reset: got %h expected 0", mem_rdata); end
    run_access(1, 1'b1, 1'b0, 28'h0000005, '0, lat, after);
    model_access(1, 1'b1, 1'b0, 28'h0000005, '0);
    vectors++;
    if (mem_rdata[LW +: LW] !== ref_rdata[1]) begin miscompares++; $display("FAIL abort_no_commit: got %h expected %h", mem_rdata[LW +: LW], ref_rdata[1]); end
  endtask

  task automatic test_random();
    logic [DL-1:0] pool [8];
    int lat, ch;
    logic after, rd;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    for (int k = 0; k < 8; k++) begin
      pool[k] = DL'($urandom());
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      a = {16'h0, pool[k]};
      run_access(k % NCH, 1'b0, 1'b1, a, d, lat, after);
      model_access(k % NCH, 1'b0, 1'b1, a, d);
    end
    for (int i = 0; i < 100; i++) begin
      ch = int'($urandom_range(0, NCH - 1));
      rd = $urandom_range(0, 9) < 6;
      a = AW'($urandom());
      a[DL-1:0] = pool[$urandom_range(0, 7)];
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_access(ch, rd, !rd, a, d, lat, after);
      model_access(ch, rd, !rd, a, d);
      vectors++;
      if (lat < LAT || lat > LAT + MAXSTALL) begin miscompares++; $display("FAIL rand_latency %0d: got %0d expected %0d..%0d", i, lat, LAT, LAT + MAXSTALL); end
      vectors++;
      if (after !== 1'b0) begin miscompares++; $display("FAIL rand_pulse %0d: got %b expected 0", i, after); end
      vectors++;
      if (mem_rdata[ch*LW +: LW] !== ref_rdata[ch]) begin miscompares++; $display("FAIL rand_rdata %0d ch%0d: got %h expected %h", i, ch, mem_rdata[ch*LW +: LW], ref_rdata[ch]); end
    end
    vectors++;
    if (protocol_err !== ref_err) begin miscompares++; $display("FAIL rand_err: got %b expected %b", protocol_err, ref_err); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alias_protocol();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
